bcd_digit_serial_adder: RTL

BCD_DIGIT_SERIAL_ADDER -- requirements
Module: bcd_digit_serial_adder

---
 rtl/bcd_digit_serial_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/bcd_digit_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, low digit first.
// Operands are latched on start; Sum/Carry_out/err update only when the result completes.
module bcd_digit_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   Addend,
    input  logic [4*DIGITS-1:0]   Augend,
    input  logic                  Carry_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Carry_out,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    state_t                  state;
    logic [DIGITS-1:0][3:0]  a_q, b_q, res_q, res_nxt;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic [4:0]              s;
    logic [3:0]              dig;
    logic                    dig_c;
    logic                    bad;

    // One BCD digit slice: binary add, then +6 correction when the sum leaves 0..9.
    always_comb begin
        s = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {4'b0, carry};
        if (s > 5'd9) begin
            dig   = 4'(s + 5'd6);
            dig_c = 1'b1;
        end else begin
            dig   = s[3:0];
            dig_c = 1'b0;
        end
        res_nxt      = res_q;
        res_nxt[idx] = dig;
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a_q[i] > 4'd9 || b_q[i] > 4'd9) bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            Sum       <= '0;
            Carry_out <= 1'b0;
            err       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= Addend;
                        b_q   <= Augend;
                        carry <= Carry_in;
                        idx   <= '0;
                        ready <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    res_q <= res_nxt;
                    carry <= dig_c;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        // Final digit resolves on this edge, so publish from res_nxt.
                        Sum       <= bad ? '0 : res_nxt;
                        Carry_out <= bad ? 1'b0 : dig_c;
                        err       <= bad;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
